// File: rtl/cpc_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpc_ram_pkg
// Purpose  : Shared types, port-decode constants and block-to-page mapping
//            for the CPC RAM expansion controller.
// Revision : 1.0  initial release
// ============================================================================
package cpc_ram_pkg;

  // Config register encodings (D2:D0 of the OUT to &7Fxx)
  typedef enum logic [2:0] {
    CFG_NONE       = 3'd0,
    CFG_BLK3_P3    = 3'd1,
    CFG_ALL        = 3'd2,
    CFG_BLK3_P3_H1 = 3'd3,
    CFG_BLK1_P0    = 3'd4,
    CFG_BLK1_P1    = 3'd5,
    CFG_BLK1_P2    = 3'd6,
    CFG_BLK1_P3    = 3'd7
  } cfg_e;

  // Config port decode: A15 low, data byte tagged with D7:D6 = 11
  localparam logic       PORT_A15 = 1'b0;
  localparam logic [1:0] PORT_D76 = 2'b11;

  typedef struct packed {
    logic       hit;
    logic [1:0] page;
  } map_t;

  // Map the CPU 16K block (A15:A14) to a 16K page of the selected bank.
  function automatic map_t page_sel(input cfg_e cfg, input logic [1:0] blk);
    map_t m;
    m.hit  = 1'b0;
    m.page = 2'd0;
    case (cfg)
      CFG_NONE: ;
      CFG_BLK3_P3, CFG_BLK3_P3_H1: begin
        if (blk == 2'd3) begin
          m.hit  = 1'b1;
          m.page = 2'd3;
        end
      end
      CFG_ALL: begin
        m.hit  = 1'b1;
        m.page = blk;
      end
      default: begin
        // cfg 4..7 place page (cfg-4) in block 1; cfg-4 is simply cfg[1:0]
        if (blk == 2'd1) begin
          m.hit  = 1'b1;
          m.page = cfg[1:0];
        end
      end
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpc_ram_cfg_reg.sv
`default_nettype none
// ============================================================================
// Module   : cpc_ram_cfg_reg
// Purpose  : Edge-qualified detector for OUT to &7Fxx and the cfg/bank
//            register it loads.
// Revision : 1.0  initial release
// ============================================================================
module cpc_ram_cfg_reg
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iorq_b,
  input  logic                 wr_b,
  input  logic                 m1_b,
  input  logic [15:0]          a,
  input  logic [7:0]           d,
  output cfg_e                 cfg,
  output logic [BANK_BITS-1:0] bank
);

  logic                 io_wr;
  logic                 io_wr_q, io_wr_d;
  cfg_e                 cfg_q, cfg_d;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic [BANK_BITS-1:0] bank_new;
  logic                 unused_bits;

  assign io_wr = !iorq_b && !wr_b && m1_b
                 && (a[15] == PORT_A15) && (d[7:6] == PORT_D76);

  // Low three bank bits come from the data byte, any extra ones from A5:A3
  generate
    if (BANK_BITS > 3) begin : g_bank_wide
      assign bank_new = {a[BANK_BITS-1:3], d[5:3]};
    end else begin : g_bank_narrow
      assign bank_new = d[5:3];
    end
  endgenerate

  assign unused_bits = ^{a[14:0], d};

  // Load once per I/O cycle: only on the first sample where the decode is true
  always_comb begin
    io_wr_d = io_wr;
    cfg_d   = cfg_q;
    bank_d  = bank_q;
    if (io_wr && !io_wr_q) begin
      cfg_d  = cfg_e'(d[2:0]);
      bank_d = bank_new;
    end
  end

  // Register state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_wr_q <= 1'b0;
      cfg_q   <= CFG_NONE;
      bank_q  <= '0;
    end else begin
      io_wr_q <= io_wr_d;
      cfg_q   <= cfg_d;
      bank_q  <= bank_d;
    end
  end

  assign cfg  = cfg_q;
  assign bank = bank_q;

endmodule
`default_nettype wire

// File: rtl/cpc_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpc_ram_ctrl
// Purpose  : CPC RAM expansion controller: bank mapping, RAMDIS generation
//            and registered SRAM strobes.
// Revision : 1.0  initial release
// ============================================================================
module cpc_ram_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS    = 3,
  parameter bit EXCLUDE_BASE = 1'b0,
  parameter int HIADR_W      = BANK_BITS + 2
) (
  input  logic               CLK,
  input  logic               RESET_B,
  input  logic [15:0]        A,
  input  logic [7:0]         D,
  input  logic               MREQ_B,
  input  logic               IOREQ_B,
  input  logic               RD_B,
  input  logic               WR_B,
  input  logic               M1_B,
  input  logic               RAMRD_B,
  output logic [HIADR_W-1:0] HIADR,
  output logic               RAMCS_B,
  output logic               RAMOE_B,
  output logic               RAMWE_B,
  output logic               RAMDIS
);

  cfg_e                 cfg;
  logic [BANK_BITS-1:0] bank;
  map_t                 map;
  logic                 hit;
  logic                 rd_set, wr_set;
  logic                 oe_q, oe_d;
  logic                 we_q, we_d;

  cpc_ram_cfg_reg #(
    .BANK_BITS (BANK_BITS)
  ) u_cfg_reg (
    .clk    (CLK),
    .rst_n  (RESET_B),
    .iorq_b (IOREQ_B),
    .wr_b   (WR_B),
    .m1_b   (M1_B),
    .a      (A),
    .d      (D),
    .cfg    (cfg),
    .bank   (bank)
  );

  assign map    = page_sel(cfg, A[15:14]);
  assign hit    = map.hit && !(EXCLUDE_BASE && (bank == '0));
  assign HIADR  = hit ? {bank, map.page} : '0;

  assign rd_set = hit && !MREQ_B && !RD_B && !RAMRD_B;
  assign wr_set = hit && !MREQ_B && !WR_B;
  assign RAMDIS = rd_set || wr_set;

  // Next strobe state (active-low); a write forces OE off so OE/WE never overlap
  always_comb begin
    we_d = we_q;
    oe_d = oe_q;
    if (wr_set) begin
      we_d = 1'b0;
    end else if (WR_B || MREQ_B) begin
      we_d = 1'b1;
    end
    if (wr_set) begin
      oe_d = 1'b1;
    end else if (rd_set) begin
      oe_d = 1'b0;
    end else if (RD_B || MREQ_B) begin
      oe_d = 1'b1;
    end
  end

  // Strobe registers; reset parks the SRAM deselected
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      oe_q <= 1'b1;
      we_q <= 1'b1;
    end else begin
      oe_q <= oe_d;
      we_q <= we_d;
    end
  end

  // Chip select follows whichever strobe is active, from the same registers
  assign RAMOE_B = oe_q;
  assign RAMWE_B = we_q;
  assign RAMCS_B = oe_q & we_q;

endmodule
`default_nettype wire
